// File: rtl/fetch_buffer_if.sv
// Core-wide widths plus the fetch stage's memory, redirect and decode handshake bundle.
// The package lives here because every user of the interface also needs these widths.
package core_pkg;
    localparam int Xlen = 32;
    localparam int Ilen = 32;
endpackage

interface fetch_buffer_if;
    import core_pkg::*;

    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [Xlen-1:0] imem_req_addr_o;
    logic            imem_resp_valid_i;
    logic [Ilen-1:0] imem_resp_data_i;
    logic            imem_resp_err_i;
    logic            redirect_valid_i;
    logic [Xlen-1:0] redirect_pc_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [Ilen-1:0] inst_o;
    logic [Xlen-1:0] pc_o;
    logic            inst_err_o;

    // Fetch stage side.
    modport master (
        output imem_req_valid_o,
        input  imem_req_ready_i,
        output imem_req_addr_o,
        input  imem_resp_valid_i,
        input  imem_resp_data_i,
        input  imem_resp_err_i,
        input  redirect_valid_i,
        input  redirect_pc_i,
        output inst_valid_o,
        input  inst_ready_i,
        output inst_o,
        output pc_o,
        output inst_err_o
    );

    // Memory / decode / redirect side.
    modport slave (
        input  imem_req_valid_o,
        output imem_req_ready_i,
        input  imem_req_addr_o,
        output imem_resp_valid_i,
        output imem_resp_data_i,
        output imem_resp_err_i,
        output redirect_valid_i,
        output redirect_pc_i,
        input  inst_valid_o,
        output inst_ready_i,
        input  inst_o,
        input  pc_o,
        input  inst_err_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: issues in-order word fetches, buffers responses with their PCs
// and hands them to decode; a redirect flushes the buffer and discards in-flight returns.
module fetch_buffer
    import core_pkg::*;
#(
    parameter logic [Xlen-1:0] ResetPc = '0,
    parameter int unsigned     Depth   = 4
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_buffer_if.master bus
);

    localparam int unsigned     CntW      = $clog2(Depth + 1);
    localparam int unsigned     PtrW      = $clog2(Depth);
    localparam logic [Xlen-1:0] AlignMask = ~Xlen'(3);
    localparam logic [Xlen-1:0] ResetPcAl = ResetPc & AlignMask;

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PtrW-1:0] ptr_t;

    logic [Xlen-1:0] fetch_pc_q, fetch_pc_d;
    logic [Xlen-1:0] resp_pc_q, resp_pc_d;
    cnt_t            outst_q, outst_d;
    cnt_t            drop_q, drop_d;
    cnt_t            count_q, count_d;
    ptr_t            head_q, head_d;
    ptr_t            tail_q, tail_d;

    logic [Ilen-1:0] inst_mem_q [Depth];
    logic [Xlen-1:0] pc_mem_q   [Depth];
    logic            err_mem_q  [Depth];

    logic            inst_valid;
    logic            pop;
    logic            push;
    logic            req_valid;
    logic            req_fire;
    logic            resp;
    logic            redirect;
    logic [CntW:0]   credit_used;
    logic [Xlen-1:0] redirect_pc_al;

    assign inst_valid     = (count_q != '0);
    assign pop            = inst_valid && bus.inst_ready_i;
    assign resp           = bus.imem_resp_valid_i;
    assign redirect       = bus.redirect_valid_i;
    assign redirect_pc_al = bus.redirect_pc_i & AlignMask;

    // Outstanding plus buffered never exceeds Depth, so every response is guaranteed a slot.
    assign credit_used = {1'b0, outst_q} + {1'b0, count_q} - (CntW + 1)'(pop);
    assign req_valid   = !rst_i && !redirect && (credit_used < (CntW + 1)'(Depth));
    assign req_fire    = req_valid && bus.imem_req_ready_i;
    assign push        = resp && (drop_q == '0) && !redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc_al;
            resp_pc_d  = redirect_pc_al;
            outst_d    = outst_q - cnt_t'(resp);
            // Every request still unanswered is stale; outst_q already counts older stale ones.
            drop_d     = outst_q - cnt_t'(resp);
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + Xlen'(4);
            end
            outst_d = outst_q + cnt_t'(req_fire) - cnt_t'(resp);
            if (resp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - cnt_t'(1);
                end else begin
                    resp_pc_d = resp_pc_q + Xlen'(4);
                end
            end
            head_d  = head_q + ptr_t'(pop);
            tail_d  = tail_q + ptr_t'(push);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= ResetPcAl;
            resp_pc_q  <= ResetPcAl;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Storage needs no reset; entries are only visible once count_q covers them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            inst_mem_q[tail_q] <= bus.imem_resp_data_i;
            pc_mem_q[tail_q]   <= resp_pc_q;
            err_mem_q[tail_q]  <= bus.imem_resp_err_i;
        end
    end

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = fetch_pc_q & AlignMask;
    assign bus.inst_valid_o     = inst_valid;
    assign bus.inst_o           = inst_mem_q[head_q];
    assign bus.pc_o             = pc_mem_q[head_q];
    assign bus.inst_err_o       = err_mem_q[head_q];

    a_resp_has_request : assert property (
        @(posedge clk_i) disable iff (rst_i) resp |-> (outst_q != '0));

    a_push_has_slot : assert property (
        @(posedge clk_i) disable iff (rst_i) push |-> ((count_q != cnt_t'(Depth)) || pop));

    a_drop_bounded : assert property (
        @(posedge clk_i) disable iff (rst_i) drop_q <= outst_q);

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a variable-latency memory model, a PC model and a scoreboard of
// expected {pc, inst, err} entries that is checked on every decode handshake.
module tb_fetch_buffer;
    import core_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_buffer_if bif ();

    fetch_buffer #(.ResetPc(RST_PC), .Depth(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t        sb[$];
    mreq_t       mq[$];
    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          cyc = 0;
    int          n_req = 0;
    int          n_pop = 0;
    logic [31:0] err_addr = 32'hFFFF_FFF0;
    logic [31:0] model_pc = RST_PC;
    logic [31:0] last_pop_pc = '0;
    logic        seen40 = 1'b0, seen44 = 1'b0, err40 = 1'b0, err44 = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    // Monitor: samples the settled handshakes just before the edge that commits them.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mq.delete();
            model_pc = RST_PC;
        end else begin
            if (bif.redirect_valid_i)
                check_eq("redir_no_req", 64'(bif.imem_req_valid_o), 64'(0));
            if (bif.inst_valid_o && bif.inst_ready_i) begin
                n_pop++;
                last_pop_pc = bif.pc_o;
                if (bif.pc_o == 32'h40) begin seen40 = 1'b1; err40 = bif.inst_err_o; end
                if (bif.pc_o == 32'h44) begin seen44 = 1'b1; err44 = bif.inst_err_o; end
                check_eq("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("pop_pc", 64'(bif.pc_o), 64'(e.pc));
                    check_eq("pop_inst", 64'(bif.inst_o), 64'(e.inst));
                    check_eq("pop_err", 64'(bif.inst_err_o), 64'(e.err));
                end
            end
            if (bif.redirect_valid_i) begin
                sb.delete();
                model_pc = bif.redirect_pc_i & ~32'h3;
            end else if (bif.imem_req_valid_o && bif.imem_req_ready_i) begin
                check_eq("req_addr", 64'(bif.imem_req_addr_o), 64'(model_pc));
                sb.push_back('{model_pc, mem_data(model_pc), model_pc == err_addr});
                mq.push_back('{bif.imem_req_addr_o, cyc + lat});
                model_pc += 32'd4;
                n_req++;
            end
        end
    end

    // In-order memory: answers each accepted request lat cycles later.
    always @(posedge clk) begin
        mreq_t m;
        #1;
        cyc++;
        bif.imem_resp_valid_i = 1'b0;
        bif.imem_resp_data_i  = '0;
        bif.imem_resp_err_i   = 1'b0;
        if (!rst && mq.size() != 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            bif.imem_resp_valid_i = 1'b1;
            bif.imem_resp_data_i  = mem_data(m.addr);
            bif.imem_resp_err_i   = (m.addr == err_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic wait_pop(input string tag, input int p);
        int k;
        k = 0;
        while (n_pop == p && k < 30) begin
            step();
            look();
            k++;
        end
        check_eq(tag, 64'(n_pop != p), 64'(1));
    endtask

    initial begin
        int p0, r0;
        logic [31:0] base;
        rst = 1'b1;
        bif.imem_req_ready_i = 1'b1;
        bif.inst_ready_i     = 1'b1;
        bif.redirect_valid_i = 1'b0;
        bif.redirect_pc_i    = '0;

        repeat (3) step();
        look();
        check_eq("rst_req_valid", 64'(bif.imem_req_valid_o), 64'(0));
        check_eq("rst_inst_valid", 64'(bif.inst_valid_o), 64'(0));
        check_eq("rst_addr", 64'(bif.imem_req_addr_o), 64'(RST_PC));

        step(); rst = 1'b0; look();
        check_eq("first_req_valid", 64'(bif.imem_req_valid_o), 64'(1));
        check_eq("first_req_addr", 64'(bif.imem_req_addr_o), 64'(RST_PC));
        step(); look();
        check_eq("no_bypass", 64'(bif.inst_valid_o), 64'(0));
        step(); look();
        check_eq("first_inst_valid", 64'(bif.inst_valid_o), 64'(1));
        check_eq("first_inst_pc", 64'(bif.pc_o), 64'(RST_PC));
        p0 = n_pop;
        repeat (16) step();
        look();
        check_eq("throughput", 64'(n_pop - p0), 64'(16));

        // Memory stalls requests: address and valid must hold while the buffer drains.
        step(); bif.imem_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            look();
            check_eq("stall_valid", 64'(bif.imem_req_valid_o), 64'(1));
            check_eq("stall_addr", 64'(bif.imem_req_addr_o), 64'(model_pc));
            step();
        end

        // Decode backpressure from an empty, idle state.
        bif.imem_req_ready_i = 1'b1;
        bif.inst_ready_i     = 1'b0;
        base = model_pc;
        r0   = n_req;
        repeat (10) step();
        look();
        check_eq("bp_req_count", 64'(n_req - r0), 64'(4));
        check_eq("bp_req_low", 64'(bif.imem_req_valid_o), 64'(0));
        check_eq("bp_full", 64'(bif.inst_valid_o), 64'(1));
        step(); bif.inst_ready_i = 1'b1; look();
        check_eq("bp_head_pc", 64'(bif.pc_o), 64'(base));
        check_eq("bp_resume_valid", 64'(bif.imem_req_valid_o), 64'(1));
        check_eq("bp_resume_addr", 64'(bif.imem_req_addr_o), 64'(base + 32'h10));
        repeat (6) step();

        // Redirect with three requests in flight on a 3-cycle memory.
        lat = 3;
        repeat (8) step();
        bif.redirect_valid_i = 1'b1;
        bif.redirect_pc_i    = 32'h100;
        look();
        step(); bif.redirect_valid_i = 1'b0; look();
        check_eq("redir_addr", 64'(bif.imem_req_addr_o), 64'(32'h100));
        check_eq("redir_penalty", 64'(bif.imem_req_valid_o), 64'(1));
        p0 = n_pop;
        wait_pop("redir_pop_seen", p0);
        check_eq("redir_first_pc", 64'(last_pop_pc), 64'(32'h100));
        repeat (6) step();

        // Misaligned redirect coinciding with a response.
        lat = 1;
        repeat (6) step();
        bif.redirect_valid_i = 1'b1;
        bif.redirect_pc_i    = 32'h203;
        look();
        check_eq("coincide_resp", 64'(bif.imem_resp_valid_i), 64'(1));
        step(); bif.redirect_valid_i = 1'b0; look();
        check_eq("align_addr", 64'(bif.imem_req_addr_o), 64'(32'h200));
        p0 = n_pop;
        wait_pop("align_pop_seen", p0);
        check_eq("align_first_pc", 64'(last_pop_pc), 64'(32'h200));
        repeat (4) step();

        // Access fault at 0x40.
        err_addr = 32'h40;
        bif.redirect_valid_i = 1'b1;
        bif.redirect_pc_i    = 32'h38;
        step(); bif.redirect_valid_i = 1'b0;
        for (int i = 0; i < 20 && !seen44; i++) step();
        look();
        check_eq("err_seen44", 64'(seen44), 64'(1));
        check_eq("err_at_40", 64'(err40), 64'(1));
        check_eq("err_at_44", 64'(err44), 64'(0));

        // Reset mid-operation with the credit exhausted.
        lat = 3;
        bif.inst_ready_i = 1'b0;
        repeat (5) step();
        rst = 1'b1; look();
        check_eq("midrst_req_low", 64'(bif.imem_req_valid_o), 64'(0));
        step(); look();
        check_eq("midrst_inst_valid", 64'(bif.inst_valid_o), 64'(0));
        step(); rst = 1'b0; bif.inst_ready_i = 1'b1; look();
        check_eq("midrst_addr", 64'(bif.imem_req_addr_o), 64'(RST_PC));
        p0 = n_pop;
        wait_pop("midrst_pop_seen", p0);
        check_eq("midrst_first_pc", 64'(last_pop_pc), 64'(RST_PC));
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
